// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core pipeline.
// Opcode constants, the bubble instruction and the fetch FSM states.
package riscv_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if_id_reg.sv
// IF/ID pipeline register with load, hold and flush.
// Flush wins over load; with neither asserted the contents are held.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int          PC_WIDTH = 64,
  parameter logic [31:0] NOP      = riscv_pkg::NOP_INSTR
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                flush,
  input  logic [PC_WIDTH-1:0] ld_pc,
  input  logic [31:0]         ld_instr,
  output logic [PC_WIDTH-1:0] if_pc,
  output logic [31:0]         if_instr,
  output logic                if_valid
);

  // Register update: flush inserts a bubble, load captures a real instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_pc    <= '0;
      if_instr <= NOP;
      if_valid <= 1'b0;
    end else if (flush) begin
      if_instr <= NOP;
      if_valid <= 1'b0;
    end else if (load) begin
      if_pc    <= ld_pc;
      if_instr <= ld_instr;
      if_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC, imem handshake, skid buffer and IF/ID register.
// Optional IFETCH_PERF_CNT_EN adds the fetch_count output.
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter int                   PC_WIDTH  = 64,
  parameter logic [PC_WIDTH-1:0]  RESET_PC  = '0,
  parameter logic [31:0]          NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic [31:0]         imem_rdata,
  output logic [PC_WIDTH-1:0] if_pc,
  output logic [31:0]         if_instr,
  output logic [6:0]          if_opcode,
  output logic                if_valid
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]         fetch_count
`endif
);

  fetch_state_t        state;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic [PC_WIDTH-1:0] skid_pc;
  logic [31:0]         skid_instr;
  logic [PC_WIDTH-1:0] tgt;
  logic [PC_WIDTH-1:0] pc_next4;

  logic                ld;
  logic                fl;
  logic [PC_WIDTH-1:0] ld_pc;
  logic [31:0]         ld_instr;

  assign tgt       = branch_target & ~PC_WIDTH'(3);
  assign pc_next4  = pc + PC_WIDTH'(4);
  assign imem_req  = reset && (state != HOLD);
  assign imem_addr = pc;
  assign if_opcode = if_instr[6:0];

  // IF/ID control: what the pipeline register does this cycle.
  always_comb begin
    ld       = 1'b0;
    fl       = 1'b0;
    ld_pc    = pc;
    ld_instr = imem_rdata;
    unique case (1'b1)
      (state == FETCH): begin
        if (imem_ready) begin
          if (branch_taken) fl = 1'b1;
          else if (!stall) ld = 1'b1;
        end else if (branch_taken || !stall) begin
          fl = 1'b1;
        end
      end
      (state == DRAIN): begin
        if (branch_taken) fl = 1'b1;
      end
      (state == HOLD): begin
        if (branch_taken) begin
          fl = 1'b1;
        end else if (!stall) begin
          ld       = 1'b1;
          ld_pc    = skid_pc;
          ld_instr = skid_instr;
        end
      end
      default: ;
    endcase
  end

  // Fetch FSM, PC, redirect register and skid buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      redirect_pc <= '0;
      skid_pc     <= '0;
      skid_instr  <= '0;
    end else begin
      unique case (1'b1)
        (state == FETCH): begin
          if (imem_ready) begin
            if (branch_taken) begin
              pc <= tgt;
            end else if (stall) begin
              skid_pc    <= pc;
              skid_instr <= imem_rdata;
              pc         <= pc_next4;
              state      <= HOLD;
            end else begin
              pc <= pc_next4;
            end
          end else if (branch_taken) begin
            redirect_pc <= tgt;
            state       <= DRAIN;
          end
        end
        (state == DRAIN): begin
          if (imem_ready) begin
            pc    <= branch_taken ? tgt : redirect_pc;
            state <= FETCH;
          end else if (branch_taken) begin
            redirect_pc <= tgt;
          end
        end
        (state == HOLD): begin
          if (branch_taken) begin
            pc    <= tgt;
            state <= FETCH;
          end else if (!stall) begin
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  // Count every real instruction that enters IF/ID.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) fetch_count <= '0;
    else if (ld && !fl) fetch_count <= fetch_count + 32'd1;
  end
`endif

  if_id_reg #(
    .PC_WIDTH (PC_WIDTH),
    .NOP      (NOP_INSTR)
  ) u_if_id (
    .clk      (clk),
    .reset    (reset),
    .load     (ld),
    .flush    (fl),
    .ld_pc    (ld_pc),
    .ld_instr (ld_instr),
    .if_pc    (if_pc),
    .if_instr (if_instr),
    .if_valid (if_valid)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch.
// Build with +define+IFETCH_PERF_CNT_EN to also check fetch_count.
module tb_instruction_fetch;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic [6:0]  if_opcode;
  logic        if_valid;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;
  logic [95:0] sbq[$];
  logic        lv = 1'b0;
  logic [63:0] lp = '0;

  instruction_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .if_pc         (if_pc),
    .if_instr      (if_instr),
    .if_opcode     (if_opcode),
    .if_valid      (if_valid)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .fetch_count   (fetch_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [63:0] a);
    logic [6:0] op;
    case (a[3:2])
      2'd0: op = OP_RTYPE;
      2'd1: op = OP_LOAD;
      2'd2: op = OP_STORE;
      default: op = OP_BRANCH;
    endcase
    return {a[26:2] ^ 25'h1A5A5A5, op};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One cycle of stimulus; dlv marks a fetch that must reach IF/ID.
  task automatic cyc(input logic rdy, input logic st, input logic br,
                     input logic [63:0] tgt, input logic dlv);
    imem_ready    = rdy;
    stall         = st;
    branch_taken  = br;
    branch_target = tgt;
    imem_rdata    = mk(imem_addr);
    if (dlv) begin
      sbq.push_back({imem_addr, mk(imem_addr)});
      exp_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: each new valid IF/ID entry must match the oldest expectation.
  always @(negedge clk) begin
    logic [95:0] e;
    if (!reset) begin
      lv = 1'b0;
    end else begin
      if (if_valid && (!lv || if_pc != lp)) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected", if_pc, 64'hDEAD);
        end else begin
          e = sbq.pop_front();
          chk("sb_pc", if_pc, e[95:32]);
          chk("sb_instr", 64'(if_instr), 64'(e[31:0]));
          chk("sb_opcode", 64'(if_opcode), 64'(e[6:0]));
        end
      end
      lv = if_valid;
      lp = if_pc;
    end
  end

  initial begin
    reset = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = '0;
    imem_ready = 1'b0;
    imem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_addr", imem_addr, 64'h0);
    chk("rst_valid", 64'(if_valid), 64'd0);
    chk("rst_pc", if_pc, 64'h0);
    chk("rst_instr", 64'(if_instr), 64'h13);
    reset = 1'b1;
    #1;
    chk("t1_addr0", imem_addr, 64'h0);
    chk("t1_req", 64'(imem_req), 64'd1);
    cyc(1, 0, 0, 0, 1);
    chk("t1_addr4", imem_addr, 64'h4);
    chk("t1_valid", 64'(if_valid), 64'd1);
    cyc(1, 0, 0, 0, 1);
    chk("t1_addr8", imem_addr, 64'h8);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("t2_addr_hold", imem_addr, 64'h8);
      chk("t2_bubble", 64'(if_valid), 64'd0);
    end
    cyc(1, 0, 0, 0, 1);
    chk("t2_pc8", if_pc, 64'h8);
    chk("t2_addrC", imem_addr, 64'hC);
    cyc(1, 1, 0, 0, 1);
    chk("t3_hold_pc", if_pc, 64'h8);
    chk("t3_req_off", 64'(imem_req), 64'd0);
    cyc(0, 1, 0, 0, 0);
    chk("t3_hold_pc2", if_pc, 64'h8);
    chk("t3_hold_v", 64'(if_valid), 64'd1);
    cyc(0, 0, 0, 0, 0);
    chk("t3_skid_pc", if_pc, 64'hC);
    chk("t3_skid_in", 64'(if_instr), 64'(mk(64'hC)));
    chk("t3_addr10", imem_addr, 64'h10);
    chk("t3_req_on", 64'(imem_req), 64'd1);
    cyc(0, 0, 1, 64'h102, 0);
    chk("t4_drain_a", imem_addr, 64'h10);
    chk("t4_flush", 64'(if_valid), 64'd0);
    cyc(0, 0, 0, 0, 0);
    chk("t4_drain_b", imem_addr, 64'h10);
    chk("t4_drain_req", 64'(imem_req), 64'd1);
    cyc(1, 0, 0, 0, 0);
    chk("t4_redir", imem_addr, 64'h100);
    chk("t4_dropped", 64'(if_valid), 64'd0);
    cyc(1, 0, 0, 0, 1);
    chk("t4_pc100", if_pc, 64'h100);
    cyc(1, 0, 1, 64'h1C, 0);
    chk("t5_br_rdy", imem_addr, 64'h1C);
    chk("t5_br_flush", 64'(if_valid), 64'd0);
    cyc(1, 0, 0, 0, 1);
    chk("t5_valid1C", 64'(if_valid), 64'd1);
    cyc(1, 1, 1, 64'h200, 0);
    chk("t5_fl_stall_v", 64'(if_valid), 64'd0);
    chk("t5_fl_stall_i", 64'(if_instr), 64'h13);
    chk("t5_fl_stall_a", imem_addr, 64'h200);
    cyc(0, 0, 1, 64'h300, 0);
    cyc(1, 0, 1, 64'h400, 0);
    chk("t6_drain_br", imem_addr, 64'h400);
    cyc(1, 1, 0, 0, 0);
    chk("t6_hold_req", 64'(imem_req), 64'd0);
    cyc(0, 1, 1, 64'h40, 0);
    chk("t6_hold_br_a", imem_addr, 64'h40);
    chk("t6_hold_br_v", 64'(if_valid), 64'd0);
    cyc(1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    cyc(1, 0, 0, 0, 1);
    chk("t7_wrap", imem_addr, 64'h0);
    cyc(0, 0, 0, 0, 0);
`ifdef IFETCH_PERF_CNT_EN
    chk("pc_cnt", 64'(fetch_count), 64'(exp_cnt));
`endif
    cyc(0, 0, 1, 64'h80, 0);
    chk("t8_drain", imem_addr, 64'h0);
    chk("sb_drained", 64'(sbq.size()), 64'd0);
    #2;
    reset = 1'b0;
    imem_ready = 1'b0;
    branch_taken = 1'b0;
    #1;
    chk("t8_rst_req", 64'(imem_req), 64'd0);
    chk("t8_rst_v", 64'(if_valid), 64'd0);
    chk("t8_rst_pc", if_pc, 64'h0);
    chk("t8_rst_i", 64'(if_instr), 64'h13);
`ifdef IFETCH_PERF_CNT_EN
    chk("t8_rst_cnt", 64'(fetch_count), 64'd0);
`endif
    sbq.delete();
    exp_cnt = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("t8_restart", imem_addr, 64'h0);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    chk("t8_addr8", imem_addr, 64'h8);
    cyc(0, 1, 0, 0, 0);
`ifdef IFETCH_PERF_CNT_EN
    chk("t8_cnt", 64'(fetch_count), 64'(exp_cnt));
`endif
    chk("sb_left", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
